// File: rtl/rapcore_pinmux_if.sv
// Wishbone slave bus carrying configuration accesses into the rapcore pad multiplexer.
interface rapcore_pinmux_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/rapcore_pinmux.sv
// Runtime-programmable pad multiplexer: double-buffered pad/input routing written over
// Wishbone, applied atomically on commit, with input synchronisers and per-pad inversion.
module rapcore_pinmux #(
    parameter int NUM_PADS = 38,
    parameter int NUM_OUT  = 16,
    parameter int NUM_IN   = 8,
    parameter int SEL_W    = 6
) (
    input  logic                CLK,
    input  logic                resetn,
    rapcore_pinmux_if.slave     wb,
    input  logic [NUM_OUT-1:0]  core_out,
    output logic [NUM_IN-1:0]   core_in,
    input  logic [NUM_PADS-1:0] io_in,
    output logic [NUM_PADS-1:0] io_out,
    output logic [NUM_PADS-1:0] io_oeb
);
    localparam logic [9:0] CTRL_W   = 10'h000;
    localparam logic [9:0] STATUS_W = 10'h001;
    localparam logic [9:0] PAD_BASE = 10'h040;
    localparam logic [9:0] IN_BASE  = 10'h080;

    logic                            req_s, accept_s, wr_s, shadow_wr_s;
    logic [9:0]                      word_s, pad_off_s, in_off_s;
    logic [NUM_PADS-1:0]             pad_hit_s, drive_s, pad_src_s;
    logic [NUM_IN-1:0]               in_hit_s, in_src_s;
    logic [31:0]                     rdata_s;
    logic                            enable_d, commit_d, pending_d;
    logic [NUM_PADS-1:0][SEL_W-1:0]  sh_osel_d;
    logic [NUM_PADS-1:0]             sh_out_d, sh_inv_d;
    logic [NUM_IN-1:0][SEL_W-1:0]    sh_insel_d;

    logic                            ack_q, busy_q, enable_q, commit_q, pending_q;
    logic [31:0]                     dat_q;
    logic [NUM_PADS-1:0][SEL_W-1:0]  sh_osel_q, act_osel_q;
    logic [NUM_PADS-1:0]             sh_out_q, sh_inv_q, act_out_q, act_inv_q;
    logic [NUM_IN-1:0][SEL_W-1:0]    sh_insel_q, act_insel_q;
    logic [NUM_PADS-1:0]             sync1_q, sync2_q, io_out_q, io_oeb_q;
    logic [NUM_IN-1:0]               core_in_q;

    logic unused_s;
    assign unused_s = ^{wb.wbs_adr_i[31:12], wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:10],
                        wb.wbs_dat_i[7:SEL_W], wb.wbs_sel_i[3:2]};

    // Out-of-range offsets wrap to large values, so a plain equality compare rejects them.
    assign word_s    = wb.wbs_adr_i[11:2];
    assign pad_off_s = word_s - PAD_BASE;
    assign in_off_s  = word_s - IN_BASE;

    // Address decode and shadow read-back mux.
    always_comb begin
        rdata_s = (word_s == CTRL_W)   ? {30'd0, enable_q, 1'b0} :
                  (word_s == STATUS_W) ? {31'd0, pending_q} : 32'd0;
        for (int p = 0; p < NUM_PADS; p++) begin
            pad_hit_s[p] = (pad_off_s == 10'(p));
            rdata_s = rdata_s | (pad_hit_s[p] ?
                      ({22'd0, sh_inv_q[p], sh_out_q[p], 8'd0} | 32'(sh_osel_q[p])) : 32'd0);
        end
        for (int i = 0; i < NUM_IN; i++) begin
            in_hit_s[i] = (in_off_s == 10'(i));
            rdata_s = rdata_s | (in_hit_s[i] ? 32'(sh_insel_q[i]) : 32'd0);
        end
    end

    // Handshake qualification and byte-lane-masked shadow/control next state.
    always_comb begin
        req_s       = wb.wbs_stb_i & wb.wbs_cyc_i;
        accept_s    = req_s & ~busy_q;
        wr_s        = accept_s & wb.wbs_we_i;
        shadow_wr_s = wr_s & ((|pad_hit_s) | (|in_hit_s));
        enable_d    = (wr_s && word_s == CTRL_W && wb.wbs_sel_i[0]) ? wb.wbs_dat_i[1] : enable_q;
        commit_d    = wr_s && word_s == CTRL_W && wb.wbs_sel_i[0] && wb.wbs_dat_i[0];
        // A fresh shadow write re-raises PENDING even if a commit lands in the same cycle.
        pending_d   = shadow_wr_s ? 1'b1 : (commit_q ? 1'b0 : pending_q);
        for (int p = 0; p < NUM_PADS; p++) begin
            sh_osel_d[p] = (wr_s && pad_hit_s[p] && wb.wbs_sel_i[0]) ? wb.wbs_dat_i[SEL_W-1:0] : sh_osel_q[p];
            sh_out_d[p]  = (wr_s && pad_hit_s[p] && wb.wbs_sel_i[1]) ? wb.wbs_dat_i[8] : sh_out_q[p];
            sh_inv_d[p]  = (wr_s && pad_hit_s[p] && wb.wbs_sel_i[1]) ? wb.wbs_dat_i[9] : sh_inv_q[p];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            sh_insel_d[i] = (wr_s && in_hit_s[i] && wb.wbs_sel_i[0]) ? wb.wbs_dat_i[SEL_W-1:0] : sh_insel_q[i];
        end
    end

    // Bus response, control, shadow and active configuration registers.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            dat_q       <= 32'd0;
            enable_q    <= 1'b0;
            commit_q    <= 1'b0;
            pending_q   <= 1'b0;
            sh_osel_q   <= '0;
            sh_out_q    <= '0;
            sh_inv_q    <= '0;
            sh_insel_q  <= '0;
            act_osel_q  <= '0;
            act_out_q   <= '0;
            act_inv_q   <= '0;
            act_insel_q <= '0;
        end else begin
            ack_q      <= accept_s;
            busy_q     <= req_s;
            dat_q      <= (accept_s && !wb.wbs_we_i) ? rdata_s : 32'd0;
            enable_q   <= enable_d;
            commit_q   <= commit_d;
            pending_q  <= pending_d;
            sh_osel_q  <= sh_osel_d;
            sh_out_q   <= sh_out_d;
            sh_inv_q   <= sh_inv_d;
            sh_insel_q <= sh_insel_d;
            if (commit_q) begin
                act_osel_q  <= sh_osel_q;
                act_out_q   <= sh_out_q;
                act_inv_q   <= sh_inv_q;
                act_insel_q <= sh_insel_q;
            end
        end
    end

    // Routing muxes; unmatched selects (out of range) leave the source at 0.
    always_comb begin
        pad_src_s = '0;
        in_src_s  = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            drive_s[p] = enable_q & act_out_q[p];
            for (int k = 0; k < NUM_OUT; k++) begin
                pad_src_s[p] = pad_src_s[p] | ((act_osel_q[p] == SEL_W'(k)) & core_out[k]);
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                in_src_s[i] = in_src_s[i] | ((act_insel_q[i] == SEL_W'(p)) & (sync2_q[p] ^ act_inv_q[p]));
            end
        end
    end

    // Input synchronisers and registered pad/core outputs.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            io_out_q  <= '0;
            io_oeb_q  <= '1;
            core_in_q <= '0;
        end else begin
            sync1_q   <= io_in;
            sync2_q   <= sync1_q;
            io_out_q  <= drive_s & (pad_src_s ^ act_inv_q);
            io_oeb_q  <= ~drive_s;
            core_in_q <= in_src_s;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign io_out       = io_out_q;
    assign io_oeb       = io_oeb_q;
    assign core_in      = core_in_q;
endmodule

// File: tb/tb_rapcore_pinmux.sv
// Scoreboard bench for rapcore_pinmux: directed Wishbone traffic queues expected read data,
// a negedge monitor pops on every ack; pad/core paths are checked against hand-computed values.
module tb_rapcore_pinmux;
    localparam int NUM_PADS = 38;
    localparam int NUM_OUT  = 16;
    localparam int NUM_IN   = 8;
    localparam logic [37:0] ALL_IN = {38{1'b1}};

    typedef struct {
        logic        is_read;
        logic [31:0] adr;
        logic [31:0] data;
    } exp_t;

    logic                clk;
    logic                resetn;
    logic [NUM_OUT-1:0]  core_out;
    logic [NUM_IN-1:0]   core_in;
    logic [NUM_PADS-1:0] io_in;
    logic [NUM_PADS-1:0] io_out;
    logic [NUM_PADS-1:0] io_oeb;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   ack_cnt  = 0;
    int   base_cnt;

    rapcore_pinmux_if bus();

    rapcore_pinmux #(.NUM_PADS(NUM_PADS), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .SEL_W(6)) dut (
        .CLK     (clk),
        .resetn  (resetn),
        .wb      (bus),
        .core_out(core_out),
        .core_in (core_in),
        .io_in   (io_in),
        .io_out  (io_out),
        .io_oeb  (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every ack consumes one scoreboard entry; reads compare the returned data.
    always @(negedge clk) begin
        if (bus.wbs_ack_o === 1'b1) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: ack seen with dat_o 0x%0h and no transfer queued", bus.wbs_dat_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_read)
                    chk($sformatf("rd_0x%03h", mon_e.adr[11:0]), {32'd0, bus.wbs_dat_o}, {32'd0, mon_e.data});
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp_rd);
        exp_t e;
        bit   got;
        e.is_read = !we;
        e.adr     = adr;
        e.data    = exp_rd;
        @(negedge clk);
        exp_q.push_back(e);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL wb_timeout: adr 0x%0h got no ack within 8 cycles, required one", adr);
            void'(exp_q.pop_back());
        end
        @(negedge clk);
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_xfer(1'b1, adr, dat, sel, 32'd0);
    endtask

    task automatic wb_rd(input logic [31:0] adr, input logic [31:0] exp);
        wb_xfer(1'b0, adr, 32'd0, 4'hF, exp);
    endtask

    initial begin
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'd0;
        bus.wbs_dat_i = 32'd0;
        core_out      = 16'h0000;
        io_in         = '0;
        resetn        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_io_oeb",  {26'd0, io_oeb}, {26'd0, ALL_IN});
        chk("rst_io_out",  {26'd0, io_out}, 64'd0);
        chk("rst_core_in", {56'd0, core_in}, 64'd0);
        chk("rst_ack",     {63'd0, bus.wbs_ack_o}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        wb_rd(32'h15C, 32'h0);

        // Shadow write without commit must not reach the pad.
        core_out = 16'h0001;
        wb_wr(32'h15C, 32'h100, 4'hF);
        wb_wr(32'h000, 32'h2, 4'hF);
        repeat (3) @(negedge clk);
        chk("nocommit_oeb23", {63'd0, io_oeb[23]}, 64'd1);
        wb_rd(32'h004, 32'h1);
        wb_rd(32'h15C, 32'h100);

        // Commit: active in the cycle after ack, pad one cycle after that.
        wb_wr(32'h000, 32'h3, 4'hF);
        chk("commit_t0_oeb23", {63'd0, io_oeb[23]}, 64'd1);
        @(negedge clk);
        chk("commit_t1_oeb23", {63'd0, io_oeb[23]}, 64'd1);
        @(negedge clk);
        chk("commit_t2_oeb23", {63'd0, io_oeb[23]}, 64'd0);
        chk("commit_t2_out23", {63'd0, io_out[23]}, 64'd1);
        wb_rd(32'h004, 32'h0);
        wb_rd(32'h000, 32'h2);

        // Inverted output on pad 30 from core_out[5].
        wb_wr(32'h178, 32'h305, 4'hF);
        wb_wr(32'h000, 32'h3, 4'hF);
        repeat (2) @(negedge clk);
        chk("inv_out30_lo", {63'd0, io_out[30]}, 64'd1);
        chk("inv_oeb30",    {63'd0, io_oeb[30]}, 64'd0);
        core_out[5] = 1'b1;
        #1;
        chk("inv_out30_hold", {63'd0, io_out[30]}, 64'd1);
        @(negedge clk);
        chk("inv_out30_hi", {63'd0, io_out[30]}, 64'd0);

        // Input routing: pad 10 -> core_in[2], out-of-range pad -> core_in[3], inverted pad 30 -> core_in[4].
        wb_wr(32'h208, 32'd10, 4'hF);
        wb_wr(32'h20C, 32'd40, 4'hF);
        wb_wr(32'h210, 32'd30, 4'hF);
        wb_wr(32'h000, 32'h3, 4'hF);
        repeat (4) @(negedge clk);
        io_in[10] = 1'b1;
        @(posedge clk); #1;
        chk("in_lat1", {63'd0, core_in[2]}, 64'd0);
        @(posedge clk); #1;
        chk("in_lat2", {63'd0, core_in[2]}, 64'd0);
        @(posedge clk); #1;
        chk("in_lat3", {63'd0, core_in[2]}, 64'd1);
        io_in = ALL_IN;
        repeat (4) @(negedge clk);
        chk("in_all_ones", {56'd0, core_in}, 64'hE7);

        // Request held for four cycles yields one ack, one cycle after the request.
        base_cnt = ack_cnt;
        @(negedge clk);
        exp_q.push_back('{is_read: 1'b0 == 1'b0, adr: 32'h178, data: 32'h305});
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 32'h178;
        bus.wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        chk("hold_ack_latency", {63'd0, bus.wbs_ack_o}, 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_single_ack", 64'(ack_cnt - base_cnt), 64'd1);
        chk("dat_idle_zero", {32'd0, bus.wbs_dat_o}, 64'd0);

        // Byte lanes, unmapped and out-of-range addresses.
        wb_wr(32'h114, 32'hFFFF0305, 4'h1);
        wb_rd(32'h114, 32'h005);
        wb_wr(32'h114, 32'hFFFF0300, 4'h2);
        wb_rd(32'h114, 32'h305);
        wb_wr(32'h3FC, 32'hFFFFFFFF, 4'hF);
        wb_rd(32'h3FC, 32'h0);
        wb_wr(32'h198, 32'h100, 4'hF);
        wb_rd(32'h198, 32'h0);

        // Asynchronous reset while pads drive: outputs release with no clock edge.
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_io_oeb",  {26'd0, io_oeb}, {26'd0, ALL_IN});
        chk("arst_io_out",  {26'd0, io_out}, 64'd0);
        chk("arst_core_in", {56'd0, core_in}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        wb_rd(32'h15C, 32'h0);
        wb_rd(32'h004, 32'h0);
        wb_wr(32'h000, 32'h2, 4'hF);
        repeat (3) @(negedge clk);
        chk("arst_active_cleared", {26'd0, io_oeb}, {26'd0, ALL_IN});

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units without finishing");
        $fatal(1);
    end
endmodule

// File: doc/rapcore_pinmux.md
Name: rapcore_pinmux

Overview:
- Runtime-programmable pad multiplexer between the rapcore motor-control signals and the user GPIO pads.
- Replaces the fixed pad assignment and hard-wired output enables with Wishbone-written, double-buffered configuration.
- Applies new configuration atomically on commit.
- Adds input synchronisation, per-pad polarity inversion and a safe all-input reset state.

Parameters:
- NUM_PADS, 38, number of GPIO pads driven (io_out/io_oeb/io_in width).
- NUM_OUT, 16, number of core output signals available for routing to pads.
- NUM_IN, 8, number of core input signals fed from pads.
- SEL_W, 6, width of pad/signal select fields; must satisfy 2^SEL_W > max(NUM_PADS, NUM_OUT).

Ports:
- CLK  in  1  single block clock (Wishbone clock).
- resetn  in  1  asynchronous active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte lane select.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- core_out  in  NUM_OUT  rapcore output signals (PHASE_*, STEPOUTPUT, CIPO, ...).
- core_in  out  NUM_IN  synchronised pad inputs to rapcore (SCK, CS, ENC_A, ...).
- io_in  in  NUM_PADS  pad input values.
- io_out  out  NUM_PADS  pad output values.
- io_oeb  out  NUM_PADS  pad output-enable bar (0 = drive, 1 = input).

Behaviour:
- Register map (word address adr[11:2]):
  - 0x000 CTRL: bit0 COMMIT (write-1, self-clearing), bit1 ENABLE.
  - 0x004 STATUS (RO): bit0 PENDING = shadow differs from active since last write.
  - 0x100+4p PAD_CFG[p]: [SEL_W-1:0] OSEL, [8] OUT, [9] INV.
  - 0x200+4i IN_SEL[i]: [SEL_W-1:0] pad index.
  - Unmapped or out-of-range index: reads 0, writes ignored, still acked.
- Wishbone handshake:
  - ack asserted exactly one cycle after the first cycle with stb&cyc, held for one cycle only.
  - No back-to-back ack without stb deasserting or a new request cycle; latency is 1.
  - Byte lanes honoured on all writes.
  - wbs_dat_o is valid while ack is high and 0 otherwise.
- Shadow/active configuration:
  - Writes go to shadow registers only.
  - COMMIT copies all shadow registers to active in one cycle, the cycle after the write is acked, and clears PENDING.
  - Reads of PAD_CFG/IN_SEL return shadow values.
- Output path, per pad p with ENABLE=1 and active OUT=1:
  - io_out[p] <= core_out[OSEL] ^ INV, registered, 1-cycle latency.
  - io_oeb[p] <= 0.
  - OSEL >= NUM_OUT drives 0 ^ INV.
- Output path, OUT=0 or ENABLE=0: io_oeb[p] = 1 and io_out[p] = 0.
- Input path:
  - Each io_in bit passes a 2-flop synchroniser.
  - core_in[i] <= sync_in[IN_SEL[i]] ^ active INV of that pad, registered; total latency 3 cycles from io_in.
  - Pad index >= NUM_PADS yields 0.
  - Inputs are routed regardless of ENABLE.
- Conflicts:
  - Two pads may select the same core_out; both drive.
  - Two IN_SEL entries may select the same pad; both receive it.
- Simultaneous events: a COMMIT write while a PAD_CFG write is being acked in the same transfer is impossible, since transfers are sequential. A write and a commit in consecutive transfers commit the new value.
- Reset (async assert, sync deassert is the system's responsibility):
  - All shadow/active registers 0, CTRL 0, PENDING 0.
  - io_oeb all 1, io_out 0, core_in 0, sync flops 0.
  - wbs_ack_o 0, wbs_dat_o 0.
- Reset mid-transfer: the transfer is aborted with no ack and no register update.

Test Plan:
- Reset: after resetn low then high, io_oeb = all 1s, io_out = 0, core_in = 0; reading PAD_CFG[23] returns 0x0.
- Write PAD_CFG[23]=0x100 (OSEL 0, OUT) and CTRL=0x2 without commit; core_out[0]=1 -> io_oeb[23] stays 1, STATUS=1. Then write CTRL=0x3 -> io_oeb[23]=0 and io_out[23]=1 two cycles later; STATUS=0.
- INV: PAD_CFG[30]=0x305 (OSEL 5, OUT, INV), commit, core_out[5]=0 -> io_out[30]=1; toggling core_out[5] propagates with 1-cycle latency.
- Input route: IN_SEL[2]=10, commit, io_in[10] rising edge -> core_in[2] rises exactly 3 cycles later; IN_SEL[3]=40 -> core_in[3] stays 0.
- Wishbone: hold stb&cyc for 4 cycles -> exactly one ack, one cycle after the request. Write with wbs_sel_i=0x1 of 0xFFFF0305 -> only byte 0 updated. Read of 0x3FC returns 0 with ack.
- Async reset mid-operation: with pads driving, assert resetn low asynchronously -> io_oeb all 1 immediately without a clock edge, and the active configuration is cleared.
